// File: rtl/apb_to_obi.sv
// -----------------------------------------------------------------------------
// apb_to_obi
//
// Bridges one APB completer port onto one OBI manager port. Each APB transfer
// accepted in IDLE becomes exactly one OBI transaction:
//   IDLE -> REQ (obi_req_o high until grant) -> RESP (wait for rvalid)
//        -> DONE (answer APB with pready_o for one cycle) -> IDLE
// If the APB manager drops psel_i before DONE is served, the OBI side still
// runs to completion and the response is silently discarded.
//
// Optional feature (macro APB_TO_OBI_TIMEOUT_EN): a RESP wait longer than
// TimeoutCycles ends the transfer with pslverr=1 and prdata=0. A late rvalid
// then arrives outside RESP and is ignored. The default build has no counter.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), synchronous active-low reset
//   paddr_i .. pstrb_i      APB completer request inputs
//   prdata_o, pready_o,     APB completer response; all zero whenever
//   pslverr_o               pready_o is low
//   obi_req_o .. obi_wdata_o  OBI manager request; payload stable while req
//   obi_gnt_i, obi_rvalid_i,  OBI manager grant and response inputs
//   obi_rdata_i, obi_err_i
// -----------------------------------------------------------------------------
module apb_to_obi #(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [AddrWidth-1:0]   paddr_i,
   input  logic                   psel_i,
   input  logic                   penable_i,
   input  logic                   pwrite_i,
   input  logic [DataWidth-1:0]   pwdata_i,
   input  logic [DataWidth/8-1:0] pstrb_i,
   output logic [DataWidth-1:0]   prdata_o,
   output logic                   pready_o,
   output logic                   pslverr_o,
   output logic                   obi_req_o,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   output logic [DataWidth-1:0]   obi_wdata_o,
   input  logic                   obi_gnt_i,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic                   obi_err_i
);

   localparam int unsigned BeWidth = DataWidth / 8;

   // Word-aligns the captured address by clearing bits [1:0].
   localparam logic [AddrWidth-1:0] WordMask = {{(AddrWidth-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } state_e;

   state_e                 state_q,     state_d;
   logic                   obi_req_q,   obi_req_d;
   logic [AddrWidth-1:0]   obi_addr_q,  obi_addr_d;
   logic                   obi_we_q,    obi_we_d;
   logic [BeWidth-1:0]     obi_be_q,    obi_be_d;
   logic [DataWidth-1:0]   obi_wdata_q, obi_wdata_d;
   logic [DataWidth-1:0]   rdata_q,     rdata_d;
   logic                   err_q,       err_d;
   // Set once the APB manager has walked away from the current transfer.
   logic                   drop_q,      drop_d;

`ifdef APB_TO_OBI_TIMEOUT_EN
   localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
   logic [CntWidth-1:0]    cnt_q,       cnt_d;
`endif

   always_comb begin
      // NOTE: every *_d starts from its current value so no path through the
      // case below can leave a signal unassigned and infer a latch.
      state_d     = state_q;
      obi_req_d   = obi_req_q;
      obi_addr_d  = obi_addr_q;
      obi_we_d    = obi_we_q;
      obi_be_d    = obi_be_q;
      obi_wdata_d = obi_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      drop_d      = drop_q;
`ifdef APB_TO_OBI_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (psel_i) begin
               obi_addr_d  = paddr_i & WordMask;
               obi_we_d    = pwrite_i;
               obi_wdata_d = pwdata_i;
               // Reads always fetch the full word.
               obi_be_d    = pwrite_i ? pstrb_i : {BeWidth{1'b1}};
               obi_req_d   = 1'b1;
               drop_d      = 1'b0;
               state_d     = REQ;
            end
         end

         REQ: begin
            if (!psel_i) drop_d = 1'b1;
            if (obi_gnt_i) begin
               obi_req_d = 1'b0;
               state_d   = RESP;
`ifdef APB_TO_OBI_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end

         RESP: begin
            if (!psel_i) drop_d = 1'b1;
            if (obi_rvalid_i) begin
               rdata_d = obi_we_q ? '0 : obi_rdata_i;
               err_d   = obi_err_i;
               state_d = DONE;
            end
`ifdef APB_TO_OBI_TIMEOUT_EN
            else if (cnt_q == CntLast) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         DONE: begin
            // Leave after serving the access phase, or at once if the
            // response is being discarded.
            if (drop_q || !psel_i || penable_i) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the *_d values computed from the same pre-edge state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         obi_req_q   <= 1'b0;
         obi_addr_q  <= '0;
         obi_we_q    <= 1'b0;
         obi_be_q    <= '0;
         obi_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         drop_q      <= 1'b0;
`ifdef APB_TO_OBI_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         obi_req_q   <= obi_req_d;
         obi_addr_q  <= obi_addr_d;
         obi_we_q    <= obi_we_d;
         obi_be_q    <= obi_be_d;
         obi_wdata_q <= obi_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         drop_q      <= drop_d;
`ifdef APB_TO_OBI_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // Gating with rst_ni keeps the handshakes quiet for the whole reset cycle,
   // not just from the first reset edge onward.
   assign obi_req_o   = obi_req_q & rst_ni;
   assign obi_addr_o  = obi_addr_q;
   assign obi_we_o    = obi_we_q;
   assign obi_be_o    = obi_be_q;
   assign obi_wdata_o = obi_wdata_q;

   assign pready_o  = rst_ni & psel_i & penable_i & ~drop_q & (state_q == DONE);
   assign prdata_o  = pready_o ? rdata_q : '0;
   assign pslverr_o = pready_o & err_q;

endmodule

// File: tb/tb_apb_to_obi.sv
// -----------------------------------------------------------------------------
// tb_apb_to_obi
//
// Drives apb_to_obi with directed and randomized APB transfers and an OBI
// target whose grant and response delays are chosen per transfer. Expected
// outputs come from the latency rule: with setup at cycle 0, gnt stall g and
// rvalid stall r, obi_req is high in cycles 1..1+g and pready in cycle 3+g+r.
// -----------------------------------------------------------------------------
module tb_apb_to_obi;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic        obi_req, obi_we, obi_gnt, obi_rvalid, obi_err;
   logic [31:0] obi_addr, obi_wdata, obi_rdata;
   logic [3:0]  obi_be;

   always #5 clk = ~clk;

   apb_to_obi #(
      .AddrWidth    (32),
      .DataWidth    (32),
      .TimeoutCycles(TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .paddr_i     (paddr),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .pwdata_i    (pwdata),
      .pstrb_i     (pstrb),
      .prdata_o    (prdata),
      .pready_o    (pready),
      .pslverr_o   (pslverr),
      .obi_req_o   (obi_req),
      .obi_addr_o  (obi_addr),
      .obi_we_o    (obi_we),
      .obi_be_o    (obi_be),
      .obi_wdata_o (obi_wdata),
      .obi_gnt_i   (obi_gnt),
      .obi_rvalid_i(obi_rvalid),
      .obi_rdata_i (obi_rdata),
      .obi_err_i   (obi_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle expectations, written by the stimulus, read by the compare.
   bit          chk_en = 1'b0;
   logic        exp_req, exp_pready, exp_pslverr, exp_we;
   logic [31:0] exp_prdata, exp_addr, exp_wdata;
   logic [3:0]  exp_be;

   // Observations of the current transfer, used for literal checks.
   int          cur_c;
   int          req_cycles, pready_cnt, cap_lat;
   logic [31:0] cap_addr, cap_prdata, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we, cap_pslverr;

   always @(negedge clk) begin
      if (chk_en) begin
         check("obi_req", obi_req, exp_req);
         check("pready", pready, exp_pready);
         check("prdata", prdata, exp_prdata);
         check("pslverr", pslverr, exp_pslverr);
         if (exp_req) begin
            check("obi_addr", obi_addr, exp_addr);
            check("obi_we", obi_we, exp_we);
            check("obi_be", obi_be, exp_be);
            check("obi_wdata", obi_wdata, exp_wdata);
         end
      end
      if (obi_req) begin
         req_cycles++;
         cap_addr  = obi_addr;
         cap_we    = obi_we;
         cap_be    = obi_be;
         cap_wdata = obi_wdata;
      end
      if (pready) begin
         pready_cnt++;
         cap_lat     = cur_c;
         cap_prdata  = prdata;
         cap_pslverr = pslverr;
      end
   end

   task automatic idle(input int n, input int rv_at);
      for (int c = 0; c < n; c++) begin
         psel        = 1'b0;
         penable     = 1'b0;
         obi_gnt     = 1'b0;
         obi_rvalid  = (c == rv_at) || ($urandom_range(3) == 0);
         obi_rdata   = $urandom;
         obi_err     = 1'($urandom_range(1));
         exp_req     = 1'b0;
         exp_pready  = 1'b0;
         exp_prdata  = '0;
         exp_pslverr = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // One APB transfer with gnt stall g and rvalid stall r (r < 0: no rvalid,
   // the transfer ends by timeout). drop_at > 0 drops psel in that cycle.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int g, input int r,
                      input logic [31:0] rdata, input logic err, input int drop_at);
      int total;
      bit served;
      total      = (r < 0) ? 2 + g + TO : 3 + g + r;
      served     = (drop_at == 0);
      req_cycles = 0;
      pready_cnt = 0;
      cap_lat    = -1;
      exp_addr   = addr & 32'hFFFF_FFFC;
      exp_we     = we;
      exp_be     = we ? strb : 4'hF;
      exp_wdata  = wdata;
      for (int c = 0; c <= total; c++) begin
         cur_c   = c;
         psel    = served || (c < drop_at);
         penable = psel && (c > 0);
         pwrite  = we;
         paddr   = addr;
         pwdata  = wdata;
         pstrb   = strb;
         obi_gnt = (c == 1 + g);
         if (r >= 0 && c == 2 + g + r) begin
            obi_rvalid = 1'b1;
            obi_rdata  = rdata;
            obi_err    = err;
         end else begin
            // Stray rvalid outside RESP must be ignored.
            obi_rvalid = (c < 2 + g || c == total) && ($urandom_range(2) == 0);
            obi_rdata  = $urandom;
            obi_err    = 1'($urandom_range(1));
         end
         exp_req     = (c >= 1 && c <= 1 + g);
         exp_pready  = served && (c == total);
         exp_prdata  = (exp_pready && !we && r >= 0) ? rdata : 32'h0;
         exp_pslverr = exp_pready && (r < 0 || err);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic        we, err;
      int          g, r, drop;
      logic [31:0] rd;

      rst_ni = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
      exp_req = 1'b0; exp_pready = 1'b0; exp_prdata = '0; exp_pslverr = 1'b0;
      exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0; cur_c = 0;
      repeat (2) @(posedge clk);
      #1;
      // Outputs during reset and in the first cycle after it.
      chk_en = 1'b1;
      psel = 1'b1; penable = 1'b1;
      @(posedge clk); #1;
      check("rst_req", obi_req, 1'b0);
      check("rst_pready", pready, 1'b0);
      check("rst_addr", obi_addr, 32'h0);
      rst_ni = 1'b1;
      idle(2, -1);

      // Write with immediate grant and response.
      txn(1'b1, 32'h0000_1006, 32'hDEAD_BEEF, 4'h3, 0, 0, 32'h0BAD_F00D, 1'b0, 0);
      check("wr_addr", cap_addr, 32'h0000_1004);
      check("wr_we", cap_we, 1'b1);
      check("wr_be", cap_be, 4'h3);
      check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
      check("wr_lat", cap_lat, 3);
      check("wr_pslverr", cap_pslverr, 1'b0);
      check("wr_prdata", cap_prdata, 32'h0);
      idle(1, -1);

      // Read with grant delayed 4 cycles.
      txn(1'b0, 32'h0000_2000, 32'h1111_2222, 4'h1, 4, 0, 32'h1234_5678, 1'b0, 0);
      check("rd_req_cycles", req_cycles, 5);
      check("rd_addr", cap_addr, 32'h0000_2000);
      check("rd_be", cap_be, 4'hF);
      check("rd_prdata", cap_prdata, 32'h1234_5678);
      check("rd_lat", cap_lat, 7);

      // Read answered with an OBI error, then back to IDLE.
      txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 1, 32'hCAFE_0001, 1'b1, 0);
      check("err_pslverr", cap_pslverr, 1'b1);
      check("err_pready_cnt", pready_cnt, 1);
      check("err_lat", cap_lat, 5);
      idle(2, -1);

      // Abort while in RESP, then a normal transfer to 0x10.
      txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 2, 32'h7777_7777, 1'b0, 2);
      check("abort_pready_cnt", pready_cnt, 0);
      txn(1'b1, 32'h0000_0010, 32'h55AA_55AA, 4'hF, 0, 0, 32'h0, 1'b0, 0);
      check("after_abort_addr", cap_addr, 32'h0000_0010);
      check("after_abort_pready_cnt", pready_cnt, 1);
      check("after_abort_lat", cap_lat, 3);

      // Reset while in REQ.
      chk_en = 1'b0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0500;
      obi_gnt = 1'b0; obi_rvalid = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("rst_mid_req_before", obi_req, 1'b1);
      rst_ni = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_req_after", obi_req, 1'b0);
      check("rst_mid_pready", pready, 1'b0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      check("rst_mid_cycle_after_req", obi_req, 1'b0);
      check("rst_mid_cycle_after_prdata", prdata, 32'h0);
      check("rst_mid_cycle_after_pslverr", pslverr, 1'b0);
      chk_en = 1'b1;
      txn(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 0, 32'h0A0B_0C0D, 1'b0, 0);
      check("post_rst_lat", cap_lat, 3);
      check("post_rst_prdata", cap_prdata, 32'h0A0B_0C0D);

`ifdef APB_TO_OBI_TIMEOUT_EN
      // No rvalid: timeout after TO RESP cycles; late rvalid at cycle 20.
      txn(1'b0, 32'h0000_7000, 32'h0, 4'h0, 0, -1, 32'h0, 1'b0, 0);
      check("to_lat", cap_lat, 10);
      check("to_pslverr", cap_pslverr, 1'b1);
      check("to_prdata", cap_prdata, 32'h0);
      idle(12, 9);
      check("to_late_pready_cnt", pready_cnt, 1);
`endif

      // Randomized transfers.
      for (int i = 0; i < 150; i++) begin
         we   = 1'($urandom_range(1));
         g    = $urandom_range(4);
         r    = $urandom_range(5);
         err  = ($urandom_range(7) == 0);
         drop = ($urandom_range(7) == 0) ? $urandom_range(3 + g + r, 1) : 0;
         rd   = $urandom;
         txn(we, $urandom, $urandom, 4'($urandom_range(15)), g, r, rd, err, drop);
         check("rnd_pready_cnt", pready_cnt, (drop == 0) ? 1 : 0);
         check("rnd_req_cycles", req_cycles, g + 1);
         if ($urandom_range(1) == 1) idle($urandom_range(2) + 1, -1);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
